// File: rtl/pipeline_defs.sv
// Shared pipeline definitions for the fetch stage and its neighbours.
//   OP_LW / OP_SW     : primary opcodes of the load/store words
//   NOP_INSTR         : canonical bubble word (sll r0,r0,0)
//   PC_INC            : byte step between sequential fetches
//   fetch_state_e     : IF sequencing states
//   is_load()         : opcode test used by ID for the load-use stall
package pipeline_defs;

    localparam logic [5:0]  OP_LW     = 6'b100011;
    localparam logic [5:0]  OP_SW     = 6'b101011;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int unsigned PC_INC    = 4;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_BUBBLE = 2'd2
    } fetch_state_e;

    function automatic logic is_load(input logic [31:0] instr);
        return instr[31:26] == OP_LW;
    endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter storage.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high, loads RESET_PC
//   load   : when high, q takes d on the next rising edge
//   d      : next PC value
//   q      : current PC
module pc_register #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage.
// Holds the PC, runs the instruction-memory request/ready handshake and
// presents one instruction per cycle to the (enable-less) ID register,
// substituting NOP_INSTR whenever nothing valid is available.
//   clk, reset              : clock, asynchronous active-high reset
//   lw_stall                : ID decoded a load in the instruction on instr_if
//   redirect_valid/_pc      : taken branch/jump resolved in EX and its target
//   imem_req/addr           : fetch request, addr is the current PC
//   imem_rdata/ready        : memory response, may arrive in the same cycle
//   instr_if, pc_if,
//   pc_plus4_if, fetch_valid: fetch result towards ID
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = pipeline_defs::NOP_INSTR,
    parameter int unsigned PC_INC    = pipeline_defs::PC_INC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lw_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] instr_if,
    output logic [31:0] pc_if,
    output logic [31:0] pc_plus4_if,
    output logic        fetch_valid
);

    import pipeline_defs::*;

    localparam logic [31:0] PC_STEP = 32'(PC_INC);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic         pc_load;

    // Request and validity are decoded from the registered state, so the
    // address and request only move on clock edges.  The memory response
    // and a redirect squash act combinationally within the cycle.
    always_comb begin
        imem_req    = (state == ST_FETCH);
        fetch_valid = (state == ST_FETCH) && imem_ready && !redirect_valid;
        instr_if    = fetch_valid ? imem_rdata : NOP_INSTR;
        imem_addr   = pc;
        pc_if       = pc;
        pc_plus4_if = pc + PC_STEP;
    end

    // Next-PC mux: redirect beats sequential advance beats hold.
    always_comb begin
        pc_next = pc;
        pc_load = 1'b0;
        if (redirect_valid) begin
            pc_next = redirect_pc;
            pc_load = 1'b1;
        end else if (fetch_valid) begin
            pc_next = pc + PC_STEP;
            pc_load = 1'b1;
        end
    end

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk   (clk),
        .reset (reset),
        .load  (pc_load),
        .d     (pc_next),
        .q     (pc)
    );

    // A redirect always lands in FETCH, which also drops a pending load
    // bubble.  lw_stall only matters when a real instruction was issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_BOOT;
        end else if (redirect_valid) begin
            state <= ST_FETCH;
        end else begin
            unique case (state)
                ST_BOOT:   state <= ST_FETCH;
                ST_FETCH:  state <= (fetch_valid && lw_stall) ? ST_BUBBLE : ST_FETCH;
                ST_BUBBLE: state <= ST_FETCH;
                default:   state <= ST_BOOT;
            endcase
        end
    end

endmodule
